// File: rtl/tile_collision_arbiter_pkg.sv
// Shared tile-map constants and types for the collision arbiter and lookup helpers.
package tile_pkg;

    localparam int TILE_ROWS  = 30;
    localparam int TILE_COLS  = 40;
    localparam int TILE_SHIFT = 4;

    typedef logic [0:TILE_ROWS-1][0:TILE_COLS-1] tile_map_t;

    typedef enum logic [1:0] {TL, TR, BL, BR} corner_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_C0,
        S_C1,
        S_C2,
        S_C3,
        S_DONE
    } state_e;

endpackage

// File: rtl/tile_collision_arbiter_if.sv
// Requester-side bus of the collision arbiter: request, latched position, grant/done and result.
interface tile_collision_arbiter_if #(parameter int N_REQ = 2);

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0][9:0]  req_x;
    logic [N_REQ-1:0][9:0]  req_y;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   hit;
    logic [3:0]             hit_mask;

    modport master (
        output req, req_x, req_y,
        input  grant, done, hit, hit_mask
    );

    modport slave (
        input  req, req_x, req_y,
        output grant, done, hit, hit_mask
    );

endinterface

// File: rtl/tile_collision_arbiter_lookup.sv
// Combinational wall query for one pixel position; anything off the 40x30 map reads as wall.
module tile_lookup
    import tile_pkg::*;
(
    input  tile_map_t   tile_i,
    input  logic [10:0] px_i,
    input  logic [10:0] py_i,
    output logic        wall_o
);

    logic [6:0] col;
    logic [6:0] row;
    logic       unused_low;

    assign col        = px_i[10:TILE_SHIFT];
    assign row        = py_i[10:TILE_SHIFT];
    assign unused_low = ^{px_i[TILE_SHIFT-1:0], py_i[TILE_SHIFT-1:0]};

    always_comb begin
        if (col >= 7'(TILE_COLS) || row >= 7'(TILE_ROWS)) begin
            wall_o = 1'b1;
        end else begin
            wall_o = tile_i[row[4:0]][col[5:0]];
        end
    end

endmodule

// File: rtl/tile_collision_arbiter.sv
// Round-robin arbiter that serialises a four-corner sprite wall check over the shared tile map.
module tile_collision_arbiter
    import tile_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int SIZE  = 8
)
(
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  tile_map_t              Tile,
    tile_collision_arbiter_if.slave bus
);

    localparam int          RW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [10:0] OFS = 11'(SIZE - 1);

    state_e             state_q, state_d;
    logic [RW-1:0]      rr_q, rr_d;
    logic [RW-1:0]      win_q, win_d;
    logic               mask_q, mask_d;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic [2:0]         acc_q, acc_d;
    logic [3:0]         hm_q, hm_d;

    logic [N_REQ-1:0]   win_oh;
    logic [N_REQ-1:0]   elig;
    logic [RW-1:0]      pick;
    logic               pick_vld;
    corner_e            corner;
    logic [10:0]        cx, cy;
    logic               wall;
    logic [N_REQ-1:0]   grant, done;

    assign win_oh = N_REQ'(1) << win_q;
    // The requester serviced last is blind for one IDLE cycle so a late-dropped req is not re-served.
    assign elig   = bus.req & ~(mask_q ? win_oh : '0);

    always_comb begin
        case (state_q)
            S_C1:    corner = TR;
            S_C2:    corner = BL;
            S_C3:    corner = BR;
            default: corner = TL;
        endcase
        cx = {1'b0, x_q} + ((corner == TR || corner == BR) ? OFS : 11'd0);
        cy = {1'b0, y_q} + ((corner == BL || corner == BR) ? OFS : 11'd0);
    end

    tile_lookup u_lookup (
        .tile_i (Tile),
        .px_i   (cx),
        .py_i   (cy),
        .wall_o (wall)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            mask_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            hm_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            mask_q  <= mask_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            hm_q    <= hm_d;
        end
    end

    always_comb begin
        int j;
        j        = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(rr_q) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!pick_vld && elig[RW'(j)]) begin
                pick_vld = 1'b1;
                pick     = RW'(j);
            end
        end

        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        mask_d  = mask_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        hm_d    = hm_q;

        case (state_q)
            S_IDLE: begin
                mask_d = 1'b0;
                if (pick_vld) begin
                    win_d   = pick;
                    x_d     = bus.req_x[pick];
                    y_d     = bus.req_y[pick];
                    acc_d   = '0;
                    state_d = S_C0;
                end
            end
            S_C0: begin acc_d[0] = wall; state_d = S_C1; end
            S_C1: begin acc_d[1] = wall; state_d = S_C2; end
            S_C2: begin acc_d[2] = wall; state_d = S_C3; end
            // Result registers here so it becomes visible exactly in the DONE cycle.
            S_C3: begin hm_d = {wall, acc_q}; state_d = S_DONE; end
            S_DONE: begin
                rr_d    = (win_q == RW'(N_REQ - 1)) ? '0 : win_q + RW'(1);
                mask_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant = '0;
        done  = '0;
        case (state_q)
            S_C0, S_C1, S_C2, S_C3: grant = win_oh;
            S_DONE:                 done  = win_oh;
            default: ;
        endcase
    end

    assign bus.grant    = grant;
    assign bus.done     = done;
    assign bus.hit_mask = hm_q;
    assign bus.hit      = |hm_q;

endmodule

// File: doc/tile_collision_arbiter.md
Name: tile_collision_arbiter

Overview:
Shares the 30x40 tile-map bus (one bit per 16x16-pixel tile, 1 = wall) between several motion requesters, such as the player and enemy movers. Each requester submits a proposed sprite top-left pixel position. The block serialises a four-corner wall lookup over four cycles and returns a hit flag plus a per-corner hit mask. It sits between the tile map ROM and the per-object motion FSMs, which use the result to accept or reject a move.

Parameters:
N_REQ, 2, number of requesters (2..4)
SIZE, 8, sprite width/height in pixels (1..16)

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
Tile  in  [0:29][0:39]  tile map; Tile[row][col] = 1 means wall
req  in  N_REQ  per-requester request; held high until that requester's done pulse
req_x  in  N_REQ x 10  proposed sprite top-left X, pixels
req_y  in  N_REQ x 10  proposed sprite top-left Y, pixels
grant  out  N_REQ  one-hot; high for the whole lookup of the granted requester
done  out  N_REQ  one-hot, single-cycle pulse; result valid this cycle
hit  out  1  OR of hit_mask
hit_mask  out  4  bit0 TL, bit1 TR, bit2 BL, bit3 BR corner in wall

Behaviour:
- Reset (Reset_n = 0 at a Clk edge), which takes effect from any state:
  - grant = 0, done = 0, hit = 0, hit_mask = 0.
  - State = IDLE; round-robin pointer selects requester 0 as highest priority.
  - An in-flight lookup is abandoned and produces no done pulse.
- States: IDLE -> C0 -> C1 -> C2 -> C3 -> DONE -> IDLE.
- IDLE:
  - If any req bit is high, pick the winner by round-robin, starting from the index after the last granted requester.
  - Latch the winner's req_x/req_y and go to C0.
  - grant goes high from C0 and stays high through C3.
- C0..C3: look up one corner per cycle, in order TL, TR, BL, BR.
  - TL = (x, y); TR = (x+SIZE-1, y); BL = (x, y+SIZE-1); BR = (x+SIZE-1, y+SIZE-1).
  - Corner math is 11-bit, so there is no wrap.
  - col = px >> 4, row = py >> 4.
  - col >= 40 or row >= 30 is treated as a wall (bit = 1).
  - Each result accumulates into an internal mask; the outputs do not change during C0..C3.
- DONE:
  - grant = 0; done[winner] = 1 for exactly one cycle.
  - hit_mask and hit update in this cycle and hold until the next DONE or reset.
  - Round-robin pointer advances to winner+1 mod N_REQ.
- Latency: req sampled in IDLE at cycle 0 -> grant cycles 1-4 -> done at cycle 5.
  - Back-to-back throughput: one lookup per 6 cycles.
- Requester rules:
  - The requester that was just serviced is masked in the IDLE cycle right after its DONE, so a req held one cycle too long is not re-serviced.
  - If req drops during C0..C3, the lookup still completes and done still pulses.
- Tile is sampled live each cycle. A change during a lookup affects only the corners not yet checked; this is acceptable because the map is static.
- Coordinates are latched at grant, so req_x/req_y may change after the grant.

Decomposition:
- Package tile_pkg:
  - TILE_ROWS = 30, TILE_COLS = 40, TILE_SHIFT = 4.
  - typedef tile_map_t = logic [0:29][0:39].
  - Corner enum {TL, TR, BL, BR}.
  - State enum for the arbiter FSM.
- Sub-module tile_lookup: combinational. Takes (Tile, px[10:0], py[10:0]) and returns the wall bit, including the out-of-range-is-wall rule. Reused later by the renderer and the projectile logic.

Test Plan:
1. Reset_n = 0 for 3 cycles with req = 2'b11 -> grant = 0, done = 0, hit = 0, hit_mask = 0 throughout; the first grant after release is requester 0.
2. All-zero Tile; req[0] with x = 100, y = 100 -> grant = 01 in cycles 1-4; done = 01 only in cycle 5; hit = 0, hit_mask = 4'b0000.
3. Only Tile[6][7] = 1; req[1] with x = 108, y = 96 -> TR (115, 96) and BR (115, 103) map to col 7, row 6 -> done = 10 at cycle 5; hit_mask = 4'b1010, hit = 1.
4. All-zero Tile; req[0] with x = 636, y = 476 -> TR, BL and BR fall out of range -> hit_mask = 4'b1110, hit = 1; TL (col 39, row 29) is clear.
5. req = 2'b11 held, each requester dropping req after its done:
   - Grant order is 0, then 1.
   - Re-raising both afterwards grants 0 next (pointer wrapped).
   - Exactly one done pulse per lookup, with no overlap.
6. Reset_n = 0 for one cycle while in C2 -> next cycle grant = 0, state IDLE; no done for the aborted lookup; hit/hit_mask = 0.
